ascon_sub_layer_serial: RTL and testbench

- Serialized ASCON substitution layer (p_S) for the 320-bit permutation state x0..x4.
- Captures a state word and sweeps the 64 five-bit columns through NB_SBOX parallel sbox instances per cycle, then presents the substituted state.
- Sits between the constant-addition stage (upstream) and the linear-diffusion stage (downstream).
- Uses valid/ready handshakes so the permutation controller can trade area for latency.

---
 rtl/ascon_sub_layer_serial.sv | 126 ++++++++++++
 tb/tb_ascon_sub_layer_serial.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_sub_layer_serial.sv
// Serialized ASCON substitution layer: sweeps the 64 five-bit columns of the
// 320-bit state through NB_SBOX parallel sboxes per cycle, with valid/ready on both sides.

module ascon_sbox (
    input  logic [4:0] x_i,
    output logic [4:0] y_o
);
    always_comb begin
        y_o = 5'h00;
        case (x_i)
            5'h00: y_o = 5'h04;  5'h01: y_o = 5'h0b;  5'h02: y_o = 5'h1f;  5'h03: y_o = 5'h14;
            5'h04: y_o = 5'h1a;  5'h05: y_o = 5'h15;  5'h06: y_o = 5'h09;  5'h07: y_o = 5'h02;
            5'h08: y_o = 5'h1b;  5'h09: y_o = 5'h05;  5'h0a: y_o = 5'h08;  5'h0b: y_o = 5'h12;
            5'h0c: y_o = 5'h1d;  5'h0d: y_o = 5'h03;  5'h0e: y_o = 5'h06;  5'h0f: y_o = 5'h1c;
            5'h10: y_o = 5'h1e;  5'h11: y_o = 5'h13;  5'h12: y_o = 5'h07;  5'h13: y_o = 5'h0e;
            5'h14: y_o = 5'h00;  5'h15: y_o = 5'h0d;  5'h16: y_o = 5'h11;  5'h17: y_o = 5'h18;
            5'h18: y_o = 5'h10;  5'h19: y_o = 5'h0c;  5'h1a: y_o = 5'h01;  5'h1b: y_o = 5'h19;
            5'h1c: y_o = 5'h16;  5'h1d: y_o = 5'h0a;  5'h1e: y_o = 5'h0f;  5'h1f: y_o = 5'h17;
            default: y_o = 5'h00;
        endcase
    end
endmodule

module ascon_sub_layer_serial #(
    parameter int NB_SBOX = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [319:0] i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [319:0] o_state,
    output logic         o_busy
);
    localparam int NB_GROUPS = 64 / NB_SBOX;
    localparam int LOG_NB    = $clog2(NB_SBOX);
    localparam int CW        = (NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1;

    if (!(NB_SBOX == 1 || NB_SBOX == 2 || NB_SBOX == 4 || NB_SBOX == 8 ||
          NB_SBOX == 16 || NB_SBOX == 32 || NB_SBOX == 64)) begin : g_bad_nb_sbox
        $error("NB_SBOX must be a power of two between 1 and 64");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                     fsm_q, fsm_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    // Row-major view: [4] = x0 (bits 319:256) ... [0] = x4 (bits 63:0).
    logic [4:0][63:0]         st_q, st_d, st_sub;
    logic [NB_SBOX-1:0][5:0]  col;
    logic [NB_SBOX-1:0][4:0]  sb_in, sb_out;
    logic                     last;

    for (genvar g = 0; g < NB_SBOX; g++) begin : g_lane
        assign col[g]   = (6'(cnt_q) << LOG_NB) | 6'(g);
        assign sb_in[g] = {st_q[4][col[g]], st_q[3][col[g]], st_q[2][col[g]],
                           st_q[1][col[g]], st_q[0][col[g]]};
        ascon_sbox u_sbox (.x_i(sb_in[g]), .y_o(sb_out[g]));
    end

    always_comb begin
        st_sub = st_q;
        for (int g = 0; g < NB_SBOX; g++) begin
            for (int k = 0; k < 5; k++) begin
                st_sub[k][col[g]] = sb_out[g][k];
            end
        end
    end

    assign last    = (cnt_q == CW'(NB_GROUPS - 1));
    assign o_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && i_ready);
    assign o_valid = (fsm_q == DONE);
    assign o_busy  = (fsm_q == RUN) || (fsm_q == DONE);
    assign o_state = st_q;

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d  = st_q;
        case (fsm_q)
            IDLE: begin
                if (i_valid) begin
                    st_d  = i_state;
                    cnt_d = '0;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                st_d = st_sub;
                if (last) begin
                    cnt_d = '0;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // A simultaneous consume-and-load skips IDLE so there is no bubble.
                if (i_ready) begin
                    if (i_valid) begin
                        st_d  = i_state;
                        cnt_d = '0;
                        fsm_d = RUN;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end
endmodule

// File: tb/tb_ascon_sub_layer_serial.sv
// Bench for ascon_sub_layer_serial: three instances (NB_SBOX = 8, 1, 64) checked
// against a table-driven p_S model through an expected-result queue.

module tb_ascon_sub_layer_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         valid [3];
    logic         ready [3];
    logic         ordy  [3];
    logic         oval  [3];
    logic         obusy [3];
    logic [319:0] sin   [3];
    logic [319:0] sout  [3];

    int tests = 0;
    int fails = 0;
    logic [319:0] exp_q [$];

    localparam logic [4:0] SB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NB = (g == 0) ? 8 : ((g == 1) ? 1 : 64);
        ascon_sub_layer_serial #(.NB_SBOX(NB)) dut (
            .i_clk(clk), .i_rst(rst), .i_valid(valid[g]), .o_ready(ordy[g]),
            .i_state(sin[g]), .o_valid(oval[g]), .i_ready(ready[g]),
            .o_state(sout[g]), .o_busy(obusy[g]));
    end

    function automatic logic [319:0] ps(input logic [319:0] s);
        logic [319:0] r;
        logic [4:0]   a, y;
        r = s;
        for (int j = 0; j < 64; j++) begin
            a = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
            y = SB[a];
            r[256+j] = y[4]; r[192+j] = y[3]; r[128+j] = y[2]; r[64+j] = y[1]; r[j] = y[0];
        end
        return r;
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int idx, output int n);
        n = 0;
        while (!oval[idx] && n < 200) begin
            step();
            n++;
        end
    endtask

    // One transaction with i_ready held high; returns the observed o_state.
    task automatic test_single(input int idx, input logic [319:0] s, input int lat,
                               input string name, output logic [319:0] got);
        int n;
        logic [319:0] e;
        ready[idx] = 1'b1;
        sin[idx]   = s;
        valid[idx] = 1'b1;
        tests++;
        if (ordy[idx] !== 1'b1) begin
            fails++; $display("FAIL %s_accept: o_ready=%b want 1", name, ordy[idx]);
        end
        exp_q.push_back(ps(s));
        step();
        valid[idx] = 1'b0;
        tests++;
        if (obusy[idx] !== 1'b1 || oval[idx] !== 1'b0) begin
            fails++; $display("FAIL %s_run: o_busy=%b o_valid=%b want 1 0", name, obusy[idx], oval[idx]);
        end
        wait_valid(idx, n);
        tests++;
        if (n != lat) begin
            fails++; $display("FAIL %s_latency: got %0d cycles want %0d", name, n, lat);
        end
        got = sout[idx];
        tests++;
        if (exp_q.size() == 0) begin
            fails++; $display("FAIL %s_data: no expected entry queued", name);
        end else begin
            e = exp_q.pop_front();
            if (sout[idx] !== e) begin
                fails++; $display("FAIL %s_data: got %h want %h", name, sout[idx], e);
            end
        end
        step();
        tests++;
        if (oval[idx] !== 1'b0 || ordy[idx] !== 1'b1 || obusy[idx] !== 1'b0) begin
            fails++; $display("FAIL %s_idle: o_valid=%b o_ready=%b o_busy=%b want 0 1 0",
                              name, oval[idx], ordy[idx], obusy[idx]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0; ready[i] = 1'b1; sin[i] = '0;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (oval[i] !== 1'b0 || obusy[i] !== 1'b0 || ordy[i] !== 1'b1 || sout[i] !== '0) begin
                fails++; $display("FAIL reset_%0d: o_valid=%b o_busy=%b o_ready=%b o_state=%h want 0 0 1 0",
                                  i, oval[i], obusy[i], ordy[i], sout[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [319:0] got, want;
        want = {128'h0, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0};
        test_single(0, '0, 8, "zero", got);
        tests++;
        if (got !== want) begin
            fails++; $display("FAIL zero_const: got %h want %h", got, want);
        end
    endtask

    task automatic test_x4_one();
        logic [319:0] got, want;
        want = {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1};
        test_single(0, {256'h0, 64'h1}, 8, "x4one", got);
        tests++;
        if (got !== want) begin
            fails++; $display("FAIL x4one_const: got %h want %h", got, want);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [319:0] s, cap, e;
        s = rnd320();
        ready[0] = 1'b0;
        sin[0]   = s;
        valid[0] = 1'b1;
        exp_q.push_back(ps(s));
        step();
        valid[0] = 1'b0;
        wait_valid(0, n);
        tests++;
        if (n != 8) begin
            fails++; $display("FAIL bp_latency: got %0d want 8", n);
        end
        cap = sout[0];
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (oval[0] !== 1'b1 || sout[0] !== cap || ordy[0] !== 1'b0) begin
                fails++; $display("FAIL bp_hold_%0d: o_valid=%b o_ready=%b o_state=%h want 1 0 %h",
                                  k, oval[0], ordy[0], sout[0], cap);
            end
            step();
        end
        ready[0] = 1'b1;
        tests++;
        e = exp_q.pop_front();
        if (sout[0] !== e || oval[0] !== 1'b1) begin
            fails++; $display("FAIL bp_data: o_valid=%b got %h want %h", oval[0], sout[0], e);
        end
        step();
        tests++;
        if (oval[0] !== 1'b0 || ordy[0] !== 1'b1 || obusy[0] !== 1'b0) begin
            fails++; $display("FAIL bp_release: o_valid=%b o_ready=%b o_busy=%b want 0 1 0",
                              oval[0], ordy[0], obusy[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [319:0] a, b, e;
        a = rnd320();
        b = rnd320();
        ready[0] = 1'b1;
        sin[0]   = a;
        valid[0] = 1'b1;
        exp_q.push_back(ps(a));
        step();
        sin[0] = b;
        wait_valid(0, n);
        tests++;
        if (n != 8 || ordy[0] !== 1'b1) begin
            fails++; $display("FAIL b2b_first: latency %0d o_ready=%b want 8 1", n, ordy[0]);
        end
        exp_q.push_back(ps(b));
        tests++;
        e = exp_q.pop_front();
        if (sout[0] !== e) begin
            fails++; $display("FAIL b2b_data_a: got %h want %h", sout[0], e);
        end
        step();
        valid[0] = 1'b0;
        tests++;
        if (oval[0] !== 1'b0 || obusy[0] !== 1'b1) begin
            fails++; $display("FAIL b2b_nobubble: o_valid=%b o_busy=%b want 0 1", oval[0], obusy[0]);
        end
        // Second result arrives 8 cycles after its accept edge: 8 idle cycles between the two pulses.
        wait_valid(0, n);
        tests++;
        if (n != 8) begin
            fails++; $display("FAIL b2b_spacing: got %0d want 8", n);
        end
        tests++;
        e = exp_q.pop_front();
        if (sout[0] !== e) begin
            fails++; $display("FAIL b2b_data_b: got %h want %h", sout[0], e);
        end
        step();
        tests++;
        if (oval[0] !== 1'b0 || ordy[0] !== 1'b1) begin
            fails++; $display("FAIL b2b_idle: o_valid=%b o_ready=%b want 0 1", oval[0], ordy[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [319:0] s, got, want;
        s = rnd320();
        ready[0] = 1'b1;
        sin[0]   = s;
        valid[0] = 1'b1;
        exp_q.push_back(ps(s));
        step();
        valid[0] = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        tests++;
        if (oval[0] !== 1'b0 || obusy[0] !== 1'b0 || ordy[0] !== 1'b1 || sout[0] !== '0) begin
            fails++; $display("FAIL midrst_state: o_valid=%b o_busy=%b o_ready=%b o_state=%h want 0 0 1 0",
                              oval[0], obusy[0], ordy[0], sout[0]);
        end
        s    = rnd320();
        want = ps(s);
        test_single(0, s, 8, "midrst_new", got);
        tests++;
        if (got !== want) begin
            fails++; $display("FAIL midrst_residue: got %h want %h", got, want);
        end
    endtask

    task automatic test_sizes();
        logic [319:0] got;
        test_single(0, rnd320(), 8, "rand_nb8", got);
        test_single(1, rnd320(), 64, "rand_nb1", got);
        test_single(2, rnd320(), 1, "rand_nb64", got);
        test_single(2, {64'hFFFF_FFFF_FFFF_FFFF, 256'h0}, 1, "x0ones_nb64", got);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_x4_one();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sizes();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
